// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the input debouncer and the blocks
// that reuse its synchronizer.
package debounce_pkg;

  typedef enum logic [0:0] {STABLE, WAIT} db_state_e;

  localparam int unsigned DefStableCycles = 4;
  localparam logic        DefRstLevel     = 1'b1;
  localparam int unsigned DefGcntW        = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a
// parameterizable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw level; a new level is committed only after
// STABLE_CYCLES consistent synchronized samples. Rejected transitions are counted.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter logic        RST_LEVEL     = DefRstLevel,
  parameter int unsigned GCNT_W        = DefGcntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_raw,
  output logic              db_out,
  output logic              busy,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int unsigned        CntW    = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0]    CntMax  = CntW'(STABLE_CYCLES - 1);
  localparam logic [GCNT_W-1:0]  GcntMax = {GCNT_W{1'b1}};

  logic              a_sync;
  db_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              db_q, db_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;

  sync_2ff #(
    .RST_VAL(RST_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (a_raw),
    .q    (a_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      db_q    <= RST_LEVEL;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      STABLE: begin
        if (a_sync != db_q) begin
          state_d = WAIT;
          cnt_d   = CntW'(1);
        end
      end
      WAIT: begin
        // Single-bit input: any change while qualifying is a return to db_q.
        if (a_sync == db_q) begin
          state_d = STABLE;
          cnt_d   = '0;
          if (gcnt_q != GcntMax) gcnt_d = gcnt_q + 1'b1;
        end else if (cnt_q == CntMax) begin
          db_d    = a_sync;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_comb begin
    busy = (state_q == WAIT);
  end

  assign db_out     = db_q;
  assign glitch_cnt = gcnt_q;

endmodule
